// File: rtl/mem_reg_arb_pkg.sv
// Shared constants and access-type encoding for the register-file arbiter.
package mem_reg_arb_pkg;

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned STAT_BASE = 32'h18;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_HOST_WR,
    ACC_HOST_RD,
    ACC_STAT_WR
  } acc_t;

endpackage

// File: rtl/mem_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending source at or after rr, wrapping.
module rr_pick #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_SRC-1:0] i_pend,
  input  logic [IDX_W-1:0] i_rr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int j;

  // Scan from the farthest offset down so the nearest pending source wins.
  always_comb begin
    o_idx = '0;
    o_any = |i_pend;
    j     = 0;
    for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
      j = int'(i_rr) + k;
      if (j >= int'(N_SRC)) j = j - int'(N_SRC);
      if (i_pend[j]) o_idx = IDX_W'(j);
    end
  end

endmodule

// File: rtl/mem_reg_arbiter.sv
// Sole master of the register-file port: host accesses first, status shadows written back
// round-robin in idle cycles. Optional overwrite counter enabled by MEM_ARB_DROP_CNT_EN.
module mem_reg_arbiter
  import mem_reg_arb_pkg::*;
#(
  parameter int unsigned N_SRC = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    host_we,
  input  logic                    host_re,
  input  logic [ADDR_W-1:0]       host_addr,
  input  logic [DATA_W-1:0]       host_din,
  output logic [DATA_W-1:0]       host_dout,
  output logic                    host_rvalid,
  input  logic [N_SRC-1:0]        src_upd,
  input  logic [N_SRC*DATA_W-1:0] src_val,
  output logic                    mem_we,
  output logic                    mem_re,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_din,
  input  logic [DATA_W-1:0]       mem_dout
`ifdef MEM_ARB_DROP_CNT_EN
  ,
  output logic [15:0]             drop_cnt
`endif
);

  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [DATA_W-1:0] r_shadow [N_SRC];
  logic [N_SRC-1:0]  r_pend;
  logic [IDX_W-1:0]  r_rr;
  acc_t              r_acc;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_din;
  logic              r_rd_pipe;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_host_dout;

  logic [IDX_W-1:0]  w_grant_idx;
  logic              w_any;
  logic              w_host_stat;
  acc_t              w_acc_d;
  logic [ADDR_W-1:0] w_addr_d;
  logic [DATA_W-1:0] w_din_d;
  logic [N_SRC-1:0]  w_gnt_mask;

  rr_pick #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_pend (r_pend),
    .i_rr   (r_rr),
    .o_idx  (w_grant_idx),
    .o_any  (w_any)
  );

  // A host write still owns the cycle even when it targets the read-only status window.
  always_comb begin
    w_host_stat = (32'(host_addr) >= STAT_BASE) && (32'(host_addr) < STAT_BASE + N_SRC);
    w_acc_d     = ACC_NONE;
    w_addr_d    = '0;
    w_din_d     = '0;
    w_gnt_mask  = '0;
    if (host_we) begin
      if (!w_host_stat) begin
        w_acc_d  = ACC_HOST_WR;
        w_addr_d = host_addr;
        w_din_d  = host_din;
      end
    end else if (host_re) begin
      w_acc_d  = ACC_HOST_RD;
      w_addr_d = host_addr;
    end else if (w_any) begin
      w_acc_d                 = ACC_STAT_WR;
      w_addr_d                = ADDR_W'(STAT_BASE + 32'(w_grant_idx));
      w_din_d                 = r_shadow[w_grant_idx];
      w_gnt_mask[w_grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend      <= '0;
      r_rr        <= '0;
      r_acc       <= ACC_NONE;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_rd_pipe   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_host_dout <= '0;
      for (int i = 0; i < int'(N_SRC); i++) r_shadow[i] <= '0;
    end else begin
      r_acc      <= w_acc_d;
      r_mem_addr <= w_addr_d;
      r_mem_din  <= w_din_d;
      // A same-cycle update re-arms pend after the grant has taken the old shadow.
      r_pend     <= (r_pend & ~w_gnt_mask) | src_upd;
      for (int i = 0; i < int'(N_SRC); i++) begin
        if (src_upd[i]) r_shadow[i] <= src_val[i*DATA_W +: DATA_W];
      end
      if (w_acc_d == ACC_STAT_WR) begin
        r_rr <= (32'(w_grant_idx) == N_SRC - 1) ? '0 : w_grant_idx + 1'b1;
      end
      r_rd_pipe <= (r_acc == ACC_HOST_RD);
      r_rvalid  <= r_rd_pipe;
      if (r_rd_pipe) r_host_dout <= mem_dout;
    end
  end

  assign mem_we      = (r_acc == ACC_HOST_WR) || (r_acc == ACC_STAT_WR);
  assign mem_re      = (r_acc == ACC_HOST_RD);
  assign mem_addr    = r_mem_addr;
  assign mem_din     = r_mem_din;
  assign host_dout   = r_host_dout;
  assign host_rvalid = r_rvalid;

`ifdef MEM_ARB_DROP_CNT_EN
  logic [15:0]      r_drop_cnt;
  logic [N_SRC-1:0] w_ovw;
  logic [16:0]      w_drop_sum;

  always_comb begin
    w_ovw      = src_upd & r_pend & ~w_gnt_mask;
    w_drop_sum = {1'b0, r_drop_cnt};
    for (int i = 0; i < int'(N_SRC); i++) w_drop_sum = w_drop_sum + 17'(w_ovw[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_drop_cnt <= '0;
    else     r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_mem_reg_arbiter.sv
// Scoreboard bench for mem_reg_arbiter: a cycle-level reference model predicts every
// register-file access and host read response; a negedge monitor compares.
module tb_mem_reg_arbiter;

  localparam int N = 4;
  localparam int SB = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          host_we = 1'b0, host_re = 1'b0;
  logic [4:0]    host_addr = '0;
  logic [15:0]   host_din = '0;
  logic [15:0]   host_dout;
  logic          host_rvalid;
  logic [N-1:0]  src_upd = '0;
  logic [N*16-1:0] src_val = '0;
  logic          mem_we, mem_re;
  logic [4:0]    mem_addr;
  logic [15:0]   mem_din;
  logic [15:0]   mem_dout = '0;
`ifdef MEM_ARB_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  mem_reg_arbiter #(.N_SRC(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .host_we     (host_we),
    .host_re     (host_re),
    .host_addr   (host_addr),
    .host_din    (host_din),
    .host_dout   (host_dout),
    .host_rvalid (host_rvalid),
    .src_upd     (src_upd),
    .src_val     (src_val),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout)
`ifdef MEM_ARB_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file environment: one-cycle read latency.
  logic [15:0] tb_mem [32];
  initial for (int i = 0; i < 32; i++) tb_mem[i] = '0;
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_din;
    if (mem_re) mem_dout <= tb_mem[mem_addr];
  end

  typedef struct {int cyc; logic we; logic re; logic [4:0] addr; logic [15:0] din;} mem_exp_t;
  typedef struct {int cyc; logic [15:0] data;} rd_exp_t;
  typedef struct {int cyc; int val;} drop_exp_t;

  mem_exp_t  exp_mem[$];
  rd_exp_t   exp_rd[$];
  drop_exp_t exp_drop[$];

  int n_tests = 0;
  int n_fail = 0;

  // Reference model state
  logic [15:0] model_mem [32];
  logic [15:0] m_shadow [N];
  bit          m_pend [N];
  int          m_rr;
  int          m_drop;

  initial for (int i = 0; i < 32; i++) model_mem[i] = '0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_rr = 0;
    m_drop = 0;
  endtask

  function automatic bit is_stat(input logic [4:0] a);
    return (int'(a) >= SB) && (int'(a) < SB + N);
  endfunction

  // Drive one cycle of stimulus, predict its consequences, then advance to the next cycle.
  task automatic step(input logic we, input logic re, input logic [4:0] addr,
                      input logic [15:0] din, input logic [N-1:0] upd,
                      input logic [N*16-1:0] val);
    bit found;
    int i;
    host_we = we; host_re = re; host_addr = addr; host_din = din;
    src_upd = upd; src_val = val;
    if (we) begin
      if (!is_stat(addr)) begin
        exp_mem.push_back('{cyc + 1, 1'b1, 1'b0, addr, din});
        model_mem[addr] = din;
      end
    end else if (re) begin
      exp_mem.push_back('{cyc + 1, 1'b0, 1'b1, addr, 16'h0});
      exp_rd.push_back('{cyc + 3, model_mem[addr]});
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        i = (m_rr + k) % N;
        if (!found && m_pend[i]) begin
          found = 1'b1;
          exp_mem.push_back('{cyc + 1, 1'b1, 1'b0, 5'(SB + i), m_shadow[i]});
          model_mem[SB + i] = m_shadow[i];
          m_pend[i] = 1'b0;
          m_rr = (i + 1) % N;
        end
      end
    end
    for (int s = 0; s < N; s++) begin
      if (upd[s]) begin
        if (m_pend[s] && m_drop < 65535) m_drop++;
        m_shadow[s] = val[s*16 +: 16];
        m_pend[s] = 1'b1;
      end
    end
`ifdef MEM_ARB_DROP_CNT_EN
    exp_drop.push_back('{cyc + 1, m_drop});
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 1'b0, 5'h0, 16'h0, '0, '0);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mem_we", 16'(mem_we), 16'h0);
    chk("rst_mem_re", 16'(mem_re), 16'h0);
    chk("rst_mem_addr", 16'(mem_addr), 16'h0);
    chk("rst_mem_din", mem_din, 16'h0);
    chk("rst_host_dout", host_dout, 16'h0);
    chk("rst_host_rvalid", 16'(host_rvalid), 16'h0);
`ifdef MEM_ARB_DROP_CNT_EN
    chk("rst_drop_cnt", drop_cnt, 16'h0);
`endif
  endtask

  // Monitor
  mem_exp_t    me;
  rd_exp_t     re_e;
  drop_exp_t   de;
  logic [15:0] last_dout = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we || mem_re) begin
        n_tests++;
        if (mem_we && mem_re) begin
          n_fail++;
          $display("FAIL mem_both: cyc %0d we and re both high", cyc);
        end else if (exp_mem.size() == 0) begin
          n_fail++;
          $display("FAIL mem_unexpected: cyc %0d we=%b re=%b addr=%h din=%h, expected none",
                   cyc, mem_we, mem_re, mem_addr, mem_din);
        end else begin
          me = exp_mem.pop_front();
          if (me.cyc != cyc || me.we != mem_we || me.re != mem_re || me.addr != mem_addr ||
              (me.we && me.din != mem_din)) begin
            n_fail++;
            $display("FAIL mem_access: cyc %0d got we=%b re=%b addr=%h din=%h expected cyc %0d we=%b re=%b addr=%h din=%h",
                     cyc, mem_we, mem_re, mem_addr, mem_din, me.cyc, me.we, me.re, me.addr, me.din);
          end
        end
      end else if (exp_mem.size() > 0 && exp_mem[0].cyc <= cyc) begin
        me = exp_mem.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL mem_missing: cyc %0d no access, expected we=%b re=%b addr=%h din=%h",
                 cyc, me.we, me.re, me.addr, me.din);
      end

      if (host_rvalid) begin
        n_tests++;
        if (exp_rd.size() == 0) begin
          n_fail++;
          $display("FAIL rvalid_unexpected: cyc %0d dout=%h, expected no rvalid", cyc, host_dout);
        end else begin
          re_e = exp_rd.pop_front();
          last_dout = re_e.data;
          if (re_e.cyc != cyc || host_dout !== re_e.data) begin
            n_fail++;
            $display("FAIL host_read: cyc %0d dout=%h expected cyc %0d dout=%h",
                     cyc, host_dout, re_e.cyc, re_e.data);
          end
        end
      end else begin
        if (exp_rd.size() > 0 && exp_rd[0].cyc <= cyc) begin
          re_e = exp_rd.pop_front();
          last_dout = re_e.data;
          n_tests++;
          n_fail++;
          $display("FAIL rvalid_missing: cyc %0d no rvalid, expected dout=%h", cyc, re_e.data);
        end
        n_tests++;
        if (host_dout !== last_dout) begin
          n_fail++;
          $display("FAIL dout_hold: cyc %0d dout=%h expected %h", cyc, host_dout, last_dout);
        end
      end

`ifdef MEM_ARB_DROP_CNT_EN
      while (exp_drop.size() > 0 && exp_drop[0].cyc < cyc) void'(exp_drop.pop_front());
      if (exp_drop.size() > 0 && exp_drop[0].cyc == cyc) begin
        de = exp_drop.pop_front();
        n_tests++;
        if (int'(drop_cnt) != de.val) begin
          n_fail++;
          $display("FAIL drop_cnt: cyc %0d got %0d expected %0d", cyc, drop_cnt, de.val);
        end
      end
`endif
    end
  end

  initial begin
    logic [N*16-1:0] v;
    logic            we, re;
    logic [4:0]      a;
    logic [N-1:0]    u;
    int              r;
    int              busy_pct [3];

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 1'b0;

    // Host write then read-back
    step(1'b1, 1'b0, 5'h08, 16'h00A5, '0, '0);
    idle(1);
    step(1'b0, 1'b1, 5'h08, 16'h0, '0, '0);
    idle(4);

    // Simultaneous updates on all sources
    for (int i = 0; i < N; i++) v[i*16 +: 16] = 16'h1000 + 16'(i);
    step(1'b0, 1'b0, 5'h0, 16'h0, 4'b1111, v);
    idle(6);

    // Continuous updates on sources 0 and 2
    for (int c = 0; c < 8; c++) begin
      v = '0;
      v[15:0] = 16'h2000 + 16'(c);
      v[47:32] = 16'h2200 + 16'(c);
      step(1'b0, 1'b0, 5'h0, 16'h0, 4'b0101, v);
    end
    idle(4);

    // Host reads hold off a pending status write; then a dropped write to the status window
    v = '0;
    v[15:0] = 16'h3333;
    step(1'b0, 1'b1, 5'h02, 16'h0, 4'b0001, v);
    for (int c = 0; c < 10; c++) step(1'b0, 1'b1, 5'(c), 16'h0, '0, '0);
    idle(3);
    step(1'b1, 1'b0, 5'h19, 16'hDEAD, '0, '0);
    step(1'b1, 1'b1, 5'h04, 16'h4444, '0, '0);
    idle(4);

    // Overwrite under host load, then same-cycle update and grant
    v = '0;
    v[31:16] = 16'h0001;
    step(1'b0, 1'b1, 5'h01, 16'h0, 4'b0010, v);
    v[31:16] = 16'h0002;
    step(1'b0, 1'b1, 5'h01, 16'h0, 4'b0010, v);
    step(1'b0, 1'b1, 5'h01, 16'h0, '0, '0);
    idle(4);
    v[31:16] = 16'h0011;
    step(1'b0, 1'b0, 5'h0, 16'h0, 4'b0010, v);
    v[31:16] = 16'h0022;
    step(1'b0, 1'b0, 5'h0, 16'h0, 4'b0010, v);
    idle(4);

    // Randomized traffic at three host load levels
    busy_pct[0] = 10; busy_pct[1] = 45; busy_pct[2] = 85;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 250; c++) begin
        r = int'($urandom_range(0, 99));
        we = (r < busy_pct[p] / 2) || (r >= 97);
        re = (r >= busy_pct[p] / 2 && r < busy_pct[p]) || (r >= 97);
        a = ($urandom_range(0, 3) == 0) ? 5'(SB + int'($urandom_range(0, N - 1)))
                                        : 5'($urandom_range(0, 31));
        for (int s = 0; s < N; s++) u[s] = ($urandom_range(0, 99) < 20);
        v = {$urandom(), $urandom()};
        step(we, re, a, 16'($urandom()), u, v);
      end
      idle(12);
    end

    // Reset between a read's mem_re and its rvalid
    step(1'b0, 1'b1, 5'h08, 16'h0, '0, '0);
    idle(1);
    rst = 1'b1;
    exp_mem.delete();
    exp_rd.delete();
    exp_drop.delete();
    last_dout = '0;
    model_reset();
    @(negedge clk);
    chk("rst_mid_read_rvalid", 16'(host_rvalid), 16'h0);
    @(posedge clk);
    #1;
    chk("rst_mid_read_rvalid2", 16'(host_rvalid), 16'h0);
    chk_reset_outputs();
    rst = 1'b0;
    idle(4);
    chk("post_rst_no_rvalid", 16'(exp_rd.size()), 16'h0);

    chk("leftover_mem", 16'(exp_mem.size()), 16'h0);
    chk("leftover_rd", 16'(exp_rd.size()), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
